// File: rtl/lane_frame_pkg.sv
// Shared definitions for the lane frame scheduler.
//   state_t     : scheduler FSM states
//   NUM_REQ_DEF : default requester / slot count
//   DATA_W_DEF  : default slot width
//   slot_arr_t  : frame slot array at the default geometry
package lane_frame_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int DATA_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_t;

  typedef logic [0:NUM_REQ_DEF-1][DATA_W_DEF-1:0] slot_arr_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin one-hot picker.
//   req : candidate request vector
//   ptr : index where the search starts (highest priority)
//   gnt : one-hot grant of the first set req bit at or after ptr, wrapping;
//         all-zero when no bit is set
module rr_pick #(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < N; i++) begin
      idx = PTR_W'((int'(ptr) + i) % N);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lane_frame_sched.sv
// Lane frame scheduler: gathers one payload per requester into a frame of
// NUM_REQ slots, granting requesters round-robin, and presents the frame
// downstream when every slot is filled or when TIMEOUT cycles have passed
// since the first slot was filled (partial frame).
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_req, i_data : per-requester valid and payload
//   o_gnt         : one-hot grant; transfer when i_req[k] & o_gnt[k]
//   o_frm_valid   : frame presented (held until accepted)
//   i_frm_ready   : downstream accepts the presented frame
//   o_frm_data    : frame slots (unfilled slots read 0)
//   o_frm_mask    : slot-filled flags
//   o_busy        : FSM is not idle
module lane_frame_sched
  import lane_frame_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_REQ-1:0]               i_req,
  input  logic [0:NUM_REQ-1][DATA_W-1:0]   i_data,
  output logic [NUM_REQ-1:0]               o_gnt,
  output logic                             o_frm_valid,
  input  logic                             i_frm_ready,
  output logic [0:NUM_REQ-1][DATA_W-1:0]   o_frm_data,
  output logic [NUM_REQ-1:0]               o_frm_mask,
  output logic                             o_busy
);

  localparam int         PTR_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT - 1);

  state_t                           state;
  logic [PTR_W-1:0]                 rr_ptr;
  logic [NUM_REQ-1:0]               mask;
  logic [0:NUM_REQ-1][DATA_W-1:0]   slots;
  logic [3:0]                       tmo_cnt;

  logic [NUM_REQ-1:0]               cand;
  logic [NUM_REQ-1:0]               pick;
  logic [NUM_REQ-1:0]               gnt;
  logic                             xfer;
  logic [NUM_REQ-1:0]               mask_nxt;
  logic                             full_nxt;
  logic [PTR_W-1:0]                 ptr_nxt;

  // ---- grant selection (combinational) ----
  // Filled slots are excluded so a requester is granted at most once per frame.
  assign cand = i_req & ~mask;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req (cand),
    .ptr (rr_ptr),
    .gnt (pick)
  );

  // No grants while a frame is presented (including the accept cycle) or in reset.
  assign gnt      = (state != ST_HOLD && !i_rst) ? pick : '0;
  assign xfer     = |gnt;
  assign mask_nxt = mask | gnt;
  assign full_nxt = xfer && (&mask_nxt);

  always_comb begin
    ptr_nxt = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) ptr_nxt = PTR_W'((k + 1) % NUM_REQ);
    end
  end

  // ---- frame state (registered) ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      rr_ptr  <= '0;
      mask    <= '0;
      slots   <= '0;
      tmo_cnt <= '0;
    end else begin
      // A transfer is captured even in the cycle the timeout fires.
      if (xfer) begin
        rr_ptr <= ptr_nxt;
        mask   <= mask_nxt;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (gnt[k]) slots[k] <= i_data[k];
        end
      end

      case (state)
        ST_IDLE: begin
          if (full_nxt) begin
            state <= ST_HOLD;
          end else if (xfer) begin
            state   <= ST_COLLECT;
            tmo_cnt <= '0;
          end
        end
        ST_COLLECT: begin
          if (full_nxt || tmo_cnt == TMO_LAST) begin
            state <= ST_HOLD;
          end else begin
            tmo_cnt <= tmo_cnt + 4'd1;
          end
        end
        ST_HOLD: begin
          // Slots are cleared with the mask so unfilled slots always read 0.
          if (i_frm_ready) begin
            state <= ST_IDLE;
            mask  <= '0;
            slots <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---- outputs ----
  assign o_gnt       = gnt;
  assign o_frm_valid = (state == ST_HOLD);
  assign o_busy      = (state != ST_IDLE);
  assign o_frm_data  = slots;
  assign o_frm_mask  = mask;

endmodule

// File: doc/lane_frame_sched.md
LANE_FRAME_SCHED -- requirements
Module: lane_frame_sched

Interface
REQ-001 Parameter NUM_REQ, default 3: number of requesters, equal to the number of frame slots.
REQ-002 Parameter DATA_W, default 8: width of each slot.
REQ-003 Parameter TIMEOUT, default 15: cycles from first slot fill to forced partial-frame emit; legal range 1..15.
REQ-004 The block SHALL run on one clock, and reset SHALL be synchronous and active-high.
REQ-005 Port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-006 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-007 Port i_req, input, [NUM_REQ-1:0]: per-requester valid.
REQ-008 Port i_data, input, [0:NUM_REQ-1][DATA_W-1:0] (2D packed): i_data[k] is the payload of requester k.
REQ-009 Port o_gnt, output, [NUM_REQ-1:0]: one-hot grant; a transfer occurs when i_req[k] & o_gnt[k].
REQ-010 Port o_frm_valid, output, 1: frame available.
REQ-011 Port i_frm_ready, input, 1: downstream accepts the frame.
REQ-012 Port o_frm_data, output, [0:NUM_REQ-1][DATA_W-1:0] (2D packed): frame slots.
REQ-013 Port o_frm_mask, output, [NUM_REQ-1:0]: slot-filled flags.
REQ-014 Port o_busy, output, 1: high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE (no slot filled), COLLECT (at least one slot filled, frame not complete) and HOLD (frame presented).
REQ-016 In IDLE/COLLECT, o_gnt SHALL be combinational: the first k, searching round-robin from pointer rr_ptr, with i_req[k]=1 and mask[k]=0; zero if none.
REQ-017 o_gnt SHALL be all-zero in HOLD.
REQ-018 On a transfer to k, slot k SHALL capture i_data[k], mask[k] SHALL set, and rr_ptr SHALL become (k+1) mod NUM_REQ, all at the next edge.
REQ-019 At most one transfer SHALL occur per cycle, and a requester with a filled slot SHALL NOT be granted.
REQ-020 IDLE->COLLECT SHALL occur on a transfer that leaves the mask non-full.
REQ-021 IDLE->HOLD or COLLECT->HOLD SHALL occur on a transfer that makes the mask all-ones.
REQ-022 Timeout counter behaviour:
- Cleared to 0 on entering COLLECT.
- Increments by 1 each cycle in COLLECT.
- When it equals TIMEOUT-1 and no completing transfer occurs, the FSM SHALL go to HOLD with the partial mask.
- A transfer in that same cycle SHALL still be captured.
REQ-023 In HOLD: o_frm_valid=1; o_frm_data and o_frm_mask stable until accepted.
REQ-024 In HOLD, i_frm_ready=1 SHALL accept the frame, clear the mask, and return to IDLE next cycle; no grant occurs in the accept cycle.
REQ-025 o_frm_data SHALL show captured slots; slots with mask 0 SHALL read 0.
REQ-026 o_frm_valid SHALL NOT depend combinationally on i_frm_ready.
REQ-027 The handshake latency floor SHALL be 1 cycle from completing transfer to o_frm_valid.

Reset
REQ-028 When i_rst=1 at an edge, the block SHALL enter IDLE with rr_ptr=0, mask=0, slots=0 and counter=0.
REQ-029 Output values under reset SHALL be: o_frm_valid=0, o_busy=0, o_frm_mask=0, o_frm_data=0; o_gnt=0 while i_rst=1.
REQ-030 Reset in COLLECT or HOLD SHALL discard the in-flight frame with no emit.

Structure
REQ-031 The state enum, DATA_W/NUM_REQ defaults and the slot array typedef SHALL live in a shared package lane_frame_pkg.
REQ-032 The round-robin selector SHALL be one sub-module, rr_pick (inputs: request vector, pointer; output: one-hot grant).
REQ-033 The block SHALL be a single clock domain with no latches.

Verification
REQ-034 Full frame, in-order arrival:
- Stimulus: req0 with 0x11, then req1 with 0x22, then req2 with 0x33, each held until granted.
- Response: o_frm_valid rises the cycle after the third transfer; data {0x11,0x22,0x33}, mask 3'b111.
REQ-035 Round-robin with all requesting:
- Stimulus: i_req=3'b111 constant from reset, rr_ptr=0.
- Response: grants 001, 010, 100 on consecutive cycles; then HOLD with o_gnt=0.
REQ-036 Timeout with TIMEOUT=4:
- Stimulus: only req1 (0xA5).
- Response: o_frm_valid rises 4 cycles after the transfer; mask 3'b010, data {0,0xA5,0}.
REQ-037 Backpressure:
- Stimulus: frame held with i_frm_ready=0 for 10 cycles while i_req=3'b111.
- Response: data/mask stable, o_gnt=0 throughout; accept on ready returns to IDLE.
REQ-038 Reset mid-COLLECT:
- Stimulus: i_rst pulsed after 2 transfers.
- Response: next cycle mask=0, o_busy=0, rr_ptr=0, and no frame is emitted.
REQ-039 Timeout-coincident transfer:
- Stimulus: last missing slot arrives in the timeout cycle.
- Response: mask 3'b111, single frame emitted.
